// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access-size encoding, FSM states,
// default memory size and the alignment rule used at request accept.
package lsu_pkg;

    localparam int LSU_MEM_BYTES = 32;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_INV  = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        MRG,
        WR,
        RSP
    } state_e;

    // Invalid size or a half/word access not aligned to its own width.
    function automatic logic size_err(input size_e size, input logic [1:0] lo);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return lo[0];
            SZ_WORD: return (lo != 2'b00);
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: extracts/extends load data from a memory word and
// merges sub-word store data into a word (little-endian lanes).
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    assign byte_lane = rdata[{offset, 3'b000} +: 8];
    assign half_lane = rdata[{offset[1], 4'b0000} +: 16];

    always_comb begin
        load_data = '0;
        merged    = rdata;
        case (size_e'(size))
            SZ_BYTE: begin
                load_data = is_unsigned ? {24'h0, byte_lane}
                                        : {{24{byte_lane[7]}}, byte_lane};
                merged[{offset, 3'b000} +: 8] = wdata[7:0];
            end
            SZ_HALF: begin
                load_data = is_unsigned ? {16'h0, half_lane}
                                        : {{16{half_lane[15]}}, half_lane};
                merged[{offset[1], 4'b0000} +: 16] = wdata[15:0];
            end
            SZ_WORD: begin
                load_data = rdata;
                merged    = wdata;
            end
            default: begin
                load_data = '0;
                merged    = rdata;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one outstanding request, sub-word stores via read-modify-write.
// Optional out-of-bounds checking is enabled by defining LSU_BOUNDS_CHECK_EN.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_BYTES = LSU_MEM_BYTES
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_write_en,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

`ifdef LSU_BOUNDS_CHECK_EN
    localparam logic BOUNDS_EN = 1'b1;
`else
    localparam logic BOUNDS_EN = 1'b0;
`endif
    localparam logic [31:0] LAST_WORD = 32'(MEM_BYTES - 4);

    state_e      state;
    state_e      state_nxt;
    logic        accept;
    logic        req_err;
    logic        out_of_bounds;
    logic [31:0] req_word;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [1:0]  size_q;
    logic        we_q;
    logic        uns_q;
    logic [31:0] load_data;
    logic [31:0] merged;

    assign req_ready     = (state == IDLE);
    assign accept        = req_valid && req_ready;
    assign req_word      = {req_addr[31:2], 2'b00};
    assign out_of_bounds = BOUNDS_EN && (req_word > LAST_WORD);
    assign req_err       = size_err(size_e'(req_size), req_addr[1:0]) || out_of_bounds;

    // Request capture: data only, no reset needed
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            size_q  <= req_size;
            we_q    <= req_we;
            uns_q   <= req_unsigned;
        end
    end

    lsu_align u_align (
        .rdata       (mem_read_data),
        .offset      (addr_q[1:0]),
        .size        (size_q),
        .is_unsigned (uns_q),
        .wdata       (wdata_q),
        .load_data   (load_data),
        .merged      (merged)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_err)                                state_nxt = RSP;
                    else if (req_we && req_size == SZ_WORD)     state_nxt = WR;
                    else                                        state_nxt = RD;
                end
            end
            RD:      state_nxt = MRG;
            MRG:     state_nxt = we_q ? WR : RSP;
            WR:      state_nxt = RSP;
            RSP:     state_nxt = rsp_ready ? IDLE : RSP;
            default: state_nxt = IDLE;
        endcase
    end

    // Memory and response outputs are registered off the next state so they
    // line up with the cycle the FSM spends in RD/WR/RSP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid      <= 1'b0;
            rsp_rdata      <= '0;
            rsp_err        <= 1'b0;
            mem_write_en   <= 1'b0;
            mem_addr       <= '0;
            mem_write_data <= '0;
        end else begin
            mem_write_en <= (state_nxt == WR);
            if (state_nxt == RD || state_nxt == WR)
                mem_addr <= (state == IDLE) ? req_word : {addr_q[31:2], 2'b00};
            else
                mem_addr <= '0;
            if (state_nxt == WR)
                mem_write_data <= (state == IDLE) ? req_wdata : merged;
            if (state != RSP && state_nxt == RSP) begin
                rsp_valid <= 1'b1;
                rsp_err   <= (state == IDLE);
                rsp_rdata <= (state == MRG && !we_q) ? load_data : '0;
            end else if (state == RSP && rsp_ready) begin
                rsp_valid <= 1'b0;
                rsp_err   <= 1'b0;
                rsp_rdata <= '0;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios plus random traffic checked
// against a byte-array reference model; the bench owns the data memory.
module tb_load_store_unit;

    localparam int MEM_BYTES = 32;
`ifdef LSU_BOUNDS_CHECK_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic        mem_write_en;
    logic [31:0] mem_addr, mem_write_data, mem_read_data;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] mem_words [MEM_BYTES/4];
    logic [7:0]  ref_bytes [MEM_BYTES];
    logic        bd_we = 1'b0;
    int          bd_idx = 0;
    logic [31:0] bd_data = '0;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_BYTES(MEM_BYTES)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_we         (req_we),
        .req_size       (req_size),
        .req_unsigned   (req_unsigned),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_rdata      (rsp_rdata),
        .rsp_err        (rsp_err),
        .mem_write_en   (mem_write_en),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    // Synchronous memory: one-cycle read latency, out-of-range reads return all ones
    always @(posedge clk) begin
        if (bd_we)
            mem_words[bd_idx] <= bd_data;
        else if (mem_write_en && mem_addr < MEM_BYTES)
            mem_words[int'(mem_addr >> 2)] <= mem_write_data;
        mem_read_data <= (mem_addr < MEM_BYTES) ? mem_words[int'(mem_addr >> 2)] : 32'hFFFF_FFFF;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ref_byte(input logic [31:0] a);
        return (a < MEM_BYTES) ? ref_bytes[int'(a)] : 8'hFF;
    endfunction

    function automatic logic ref_err(input logic [1:0] sz, input logic [31:0] a);
        logic e;
        e = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
        if (BOUNDS && (a & ~32'h3) > MEM_BYTES - 4) e = 1'b1;
        return e;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz, input logic uns);
        int n;
        logic [31:0] v;
        n = 1 << sz;
        v = '0;
        for (int i = 0; i < n; i++) v = v | (32'(ref_byte(a + 32'(i))) << (8 * i));
        if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    task automatic ref_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
        int n;
        n = 1 << sz;
        for (int i = 0; i < n; i++)
            if (a + 32'(i) < MEM_BYTES) ref_bytes[int'(a) + i] = wd[8*i +: 8];
    endtask

    function automatic logic [31:0] ref_word(input int base);
        return {ref_bytes[base+3], ref_bytes[base+2], ref_bytes[base+1], ref_bytes[base]};
    endfunction

    task automatic txn(input string tag, input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd, input int hold,
                       output logic [31:0] rd, output logic er, output int lat, output int nwr,
                       output int wr_cyc, output logic [31:0] wr_addr);
        logic        e_err;
        logic [31:0] e_rd;
        int          e_lat, e_nwr;
        bit          got;
        e_err = ref_err(sz, addr);
        e_lat = e_err ? 1 : (!we ? 3 : (sz == 2'b10 ? 2 : 4));
        e_nwr = (e_err || !we) ? 0 : 1;
        e_rd  = (e_err || we) ? 32'h0 : ref_load(addr, sz, uns);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'h1);
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rd = '0; er = 1'b0; lat = 0; nwr = 0; wr_cyc = 0; wr_addr = '0; got = 1'b0;
        for (int cyc = 1; cyc <= 12 && !got; cyc++) begin
            if (mem_write_en) begin nwr++; wr_cyc = cyc; wr_addr = mem_addr; end
            if (rsp_valid) begin
                got = 1'b1; lat = cyc; rd = rsp_rdata; er = rsp_err;
            end else begin
                @(posedge clk); #1;
            end
        end
        n_cmp++;
        assert (got) else begin
            n_fail++;
            $error("FAIL %s_timeout: observed no rsp_valid expected rsp within 12 cycles", tag);
        end
        if (got) begin
            chk({tag, "_latency"}, 32'(lat), 32'(e_lat));
            chk({tag, "_err"}, 32'(er), 32'(e_err));
            chk({tag, "_rdata"}, rd, e_rd);
            chk({tag, "_writes"}, 32'(nwr), 32'(e_nwr));
            if (e_nwr == 1) chk({tag, "_wr_addr"}, wr_addr, addr & ~32'h3);
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                chk({tag, "_hold_valid"}, 32'(rsp_valid), 32'h1);
                chk({tag, "_hold_rdata"}, rsp_rdata, rd);
                chk({tag, "_hold_err"}, 32'(rsp_err), 32'(er));
                chk({tag, "_hold_ready"}, 32'(req_ready), 32'h0);
            end
            rsp_ready = 1'b1;
            @(posedge clk); #1;
            rsp_ready = 1'b0;
            chk({tag, "_rsp_drop"}, 32'(rsp_valid), 32'h0);
        end
        if (!e_err && we) ref_store(addr, sz, wd);
    endtask

    initial begin
        logic [31:0] rd, wa, w;
        logic        er, seen_we;
        int          lat, nwr, wc;

        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = '0; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;

        // Preload memory and the reference model while in reset
        for (int i = 0; i < MEM_BYTES / 4; i++) begin
            w = (i == 1) ? 32'h8899_AABB : $urandom;
            bd_we = 1'b1; bd_idx = i; bd_data = w;
            for (int b = 0; b < 4; b++) ref_bytes[4*i+b] = w[8*b +: 8];
            @(posedge clk); #1;
        end
        bd_we = 1'b0;

        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_rsp_err", 32'(rsp_err), 32'h0);
        chk("rst_mem_we", 32'(mem_write_en), 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_write_data, 32'h0);
        chk("rst_req_ready", 32'(req_ready), 32'h1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        txn("lb_signed", 1'b0, 2'b00, 1'b0, 32'h6, 32'h0, 0, rd, er, lat, nwr, wc, wa);
        chk("lb_signed_val", rd, 32'hFFFF_FF99);
        chk("lb_signed_cyc", 32'(lat), 32'd3);
        txn("lbu", 1'b0, 2'b00, 1'b1, 32'h6, 32'h0, 0, rd, er, lat, nwr, wc, wa);
        chk("lbu_val", rd, 32'h0000_0099);

        txn("sh", 1'b1, 2'b01, 1'b0, 32'h6, 32'h0000_1234, 0, rd, er, lat, nwr, wc, wa);
        chk("sh_cyc", 32'(lat), 32'd4);
        chk("sh_pulses", 32'(nwr), 32'd1);
        chk("sh_wr_cyc", 32'(wc), 32'd3);
        txn("lw_after_sh", 1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 0, rd, er, lat, nwr, wc, wa);
        chk("lw_after_sh_val", rd, 32'h1234_AABB);

        txn("sw", 1'b1, 2'b10, 1'b0, 32'h8, 32'hDEAD_BEEF, 0, rd, er, lat, nwr, wc, wa);
        chk("sw_wr_cyc", 32'(wc), 32'd1);
        chk("sw_wr_addr", wa, 32'h8);
        chk("sw_err", 32'(er), 32'h0);
        chk("sw_cyc", 32'(lat), 32'd2);

        txn("lh_mis", 1'b0, 2'b01, 1'b0, 32'h5, 32'h0, 0, rd, er, lat, nwr, wc, wa);
        chk("lh_mis_err", 32'(er), 32'h1);
        chk("lh_mis_rdata", rd, 32'h0);
        chk("lh_mis_cyc", 32'(lat), 32'd1);
        chk("lh_mis_writes", 32'(nwr), 32'd0);

        txn("lw_oob", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 0, rd, er, lat, nwr, wc, wa);
`ifdef LSU_BOUNDS_CHECK_EN
        chk("lw_oob_err", 32'(er), 32'h1);
        chk("lw_oob_rdata", rd, 32'h0);
`else
        chk("lw_oob_err", 32'(er), 32'h0);
        chk("lw_oob_rdata", rd, 32'hFFFF_FFFF);
`endif

        txn("bp_load", 1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 5, rd, er, lat, nwr, wc, wa);

        // Reset while a byte store sits in MRG: the write must never happen
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h9; req_wdata = 32'h0000_0055;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("rstmrg_mem_we", 32'(mem_write_en), 32'h0);
        chk("rstmrg_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rstmrg_mem_addr", mem_addr, 32'h0);
        seen_we = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (mem_write_en) seen_we = 1'b1;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (mem_write_en) seen_we = 1'b1;
        end
        chk("rstmrg_no_write", 32'(seen_we), 32'h0);
        chk("rstmrg_no_rsp", 32'(rsp_valid), 32'h0);
        txn("rstmrg_readback", 1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 0, rd, er, lat, nwr, wc, wa);
        chk("rstmrg_word", rd, 32'hDEAD_BEEF);

        for (int i = 0; i < 40; i++) begin
            txn("rand", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                32'($urandom_range(0, 39)), $urandom, int'($urandom_range(0, 2)),
                rd, er, lat, nwr, wc, wa);
        end
        for (int i = 0; i < MEM_BYTES / 4; i++) begin
            txn("final_lw", 1'b0, 2'b10, 1'b0, 32'(4 * i), 32'h0, 0, rd, er, lat, nwr, wc, wa);
            chk("final_word", rd, ref_word(4 * i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
